er_frame_scheduler: RTL and testbench

//  Sequences the single-frame error-reconciliation datapath (A+B ER pair) across a run of frames.
//  Per frame: waits for a sifted-key bank, drives start_switch/frame_round/sifted_key_addr_index,

---
 rtl/er_frame_scheduler.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_er_frame_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/er_frame_scheduler.sv
// Frame scheduler for the A+B error-reconciliation pair: launches one frame per ready
// sifted-key bank, collects finish/fail/parameter pulses, accumulates run totals.
module er_frame_scheduler #(
   parameter int FRAME_NUM         = 64,
   parameter int FRAME_ROUND_WIDTH = 6,
   parameter int LEAK_W            = 16,
   parameter int ERRCNT_W          = 16,
   parameter int TOT_W             = 24,
   parameter int TIMEOUT_CYCLES    = 2**20,
   parameter int GAP_CYCLES        = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         run_start,
   input  logic [1:0]                   sifted_bank_ready,
   output logic [1:0]                   sifted_bank_release,
   output logic                         er_start_switch,
   output logic [FRAME_ROUND_WIDTH-1:0] er_frame_round,
   output logic                         er_addr_index,
   input  logic                         A_finish,
   input  logic                         B_finish,
   input  logic                         A_fail,
   input  logic                         B_fail,
   input  logic                         A_param_valid,
   input  logic [LEAK_W-1:0]            A_leaked_info,
   input  logic [ERRCNT_W-1:0]          A_error_count,
   output logic                         frame_done,
   output logic                         frame_fail,
   output logic [TOT_W-1:0]             total_leaked,
   output logic [TOT_W-1:0]             total_errors,
   output logic [FRAME_ROUND_WIDTH:0]   fail_count,
   output logic                         busy,
   output logic                         run_done,
   output logic                         timeout_err
);

   localparam int FRW    = FRAME_ROUND_WIDTH;
   localparam int FCW    = FRW + 1;
   localparam int WD_W   = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int GC_W   = $clog2(GAP_CYCLES) + 1;
   localparam int MAX_IN = (LEAK_W > ERRCNT_W) ? LEAK_W : ERRCNT_W;
   localparam int SW     = ((TOT_W > MAX_IN) ? TOT_W : MAX_IN) + 1;

   localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GC_W-1:0] GAP_LAST   = GC_W'(GAP_CYCLES - 1);
   localparam logic [FCW-1:0]  FRAME_LAST = FCW'(FRAME_NUM);
   localparam logic [SW-1:0]   TOT_MAX_SW = {{(SW-TOT_W){1'b0}}, {TOT_W{1'b1}}};

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_KEY, S_RUN, S_COLLECT, S_GAP, S_DONE, S_ABORT
   } state_t;

   state_t              state_reg, state_next;
   logic [FCW-1:0]      frame_reg, frame_next;
   logic                ptr_reg, ptr_next;
   logic [WD_W-1:0]     wd_reg, wd_next;
   logic [GC_W-1:0]     gap_reg, gap_next;
   logic                a_fin_reg, a_fin_next;
   logic                b_fin_reg, b_fin_next;
   logic                fail_reg, fail_next;
   logic                pv_reg, pv_next;
   logic [LEAK_W-1:0]   leak_reg, leak_next;
   logic [ERRCNT_W-1:0] errcnt_reg, errcnt_next;
   logic                start_switch_reg, start_switch_next;
   logic [FRW-1:0]      frame_round_reg, frame_round_next;
   logic                addr_index_reg, addr_index_next;
   logic                frame_done_reg, frame_done_next;
   logic                frame_fail_reg, frame_fail_next;
   logic [1:0]          release_reg, release_next;
   logic [TOT_W-1:0]    total_leaked_reg, total_leaked_next;
   logic [TOT_W-1:0]    total_errors_reg, total_errors_next;
   logic [FCW-1:0]      fail_count_reg, fail_count_next;
   logic                busy_reg, busy_next;
   logic                run_done_reg, run_done_next;
   logic                timeout_reg, timeout_next;
   logic                close_fire;

   logic                a_fin_now, b_fin_now, fail_now, pv_take, wd_expired;
   logic [WD_W-1:0]     wd_step;
   logic [LEAK_W-1:0]   leak_eff;
   logic [ERRCNT_W-1:0] err_eff;
   logic [SW-1:0]       leak_sum, err_sum;
   logic [TOT_W-1:0]    leak_sat, err_sat;

   // Sticky flags see the current-cycle pulse too, so same-cycle arrivals are not lost.
   assign a_fin_now  = a_fin_reg | A_finish;
   assign b_fin_now  = b_fin_reg | B_finish;
   assign fail_now   = fail_reg | (A_finish & A_fail) | (B_finish & B_fail);
   assign pv_take    = A_param_valid & ~pv_reg;
   assign wd_expired = (wd_reg == WD_LAST);
   assign wd_step    = wd_expired ? wd_reg : wd_reg + 1'b1;

   // A parameter pulse arriving in the closing cycle is used directly.
   assign leak_eff = pv_reg ? leak_reg   : A_leaked_info;
   assign err_eff  = pv_reg ? errcnt_reg : A_error_count;
   assign leak_sum = {{(SW-TOT_W){1'b0}}, total_leaked_reg} + {{(SW-LEAK_W){1'b0}}, leak_eff};
   assign err_sum  = {{(SW-TOT_W){1'b0}}, total_errors_reg} + {{(SW-ERRCNT_W){1'b0}}, err_eff};
   assign leak_sat = (leak_sum > TOT_MAX_SW) ? {TOT_W{1'b1}} : leak_sum[TOT_W-1:0];
   assign err_sat  = (err_sum  > TOT_MAX_SW) ? {TOT_W{1'b1}} : err_sum[TOT_W-1:0];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_release
         assign release_next[gi] = close_fire && (ptr_reg == 1'(gi));
      end
   endgenerate

   always_comb begin
      state_next        = state_reg;
      frame_next        = frame_reg;
      ptr_next          = ptr_reg;
      wd_next           = wd_reg;
      gap_next          = gap_reg;
      a_fin_next        = a_fin_reg;
      b_fin_next        = b_fin_reg;
      fail_next         = fail_reg;
      pv_next           = pv_reg;
      leak_next         = leak_reg;
      errcnt_next       = errcnt_reg;
      start_switch_next = start_switch_reg;
      frame_round_next  = frame_round_reg;
      addr_index_next   = addr_index_reg;
      frame_done_next   = 1'b0;
      frame_fail_next   = 1'b0;
      run_done_next     = 1'b0;
      close_fire        = 1'b0;
      total_leaked_next = total_leaked_reg;
      total_errors_next = total_errors_reg;
      fail_count_next   = fail_count_reg;
      busy_next         = busy_reg;
      timeout_next      = timeout_reg;

      case (state_reg)
         S_IDLE: begin
            if (run_start) begin
               total_leaked_next = '0;
               total_errors_next = '0;
               fail_count_next   = '0;
               timeout_next      = 1'b0;
               frame_next        = '0;
               ptr_next          = 1'b0;
               busy_next         = 1'b1;
               a_fin_next        = 1'b0;
               b_fin_next        = 1'b0;
               fail_next         = 1'b0;
               pv_next           = 1'b0;
               state_next        = S_WAIT_KEY;
            end
         end
         S_WAIT_KEY: begin
            if (sifted_bank_ready[ptr_reg]) begin
               addr_index_next   = ptr_reg;
               frame_round_next  = frame_reg[FRW-1:0];
               start_switch_next = 1'b1;
               wd_next           = '0;
               state_next        = S_RUN;
            end
         end
         S_RUN: begin
            a_fin_next = a_fin_now;
            b_fin_next = b_fin_now;
            fail_next  = fail_now;
            if (pv_take) begin
               pv_next     = 1'b1;
               leak_next   = A_leaked_info;
               errcnt_next = A_error_count;
            end
            if (a_fin_now && b_fin_now) begin
               wd_next    = wd_step;
               state_next = S_COLLECT;
            end else if (wd_expired) begin
               start_switch_next = 1'b0;
               timeout_next      = 1'b1;
               busy_next         = 1'b0;
               state_next        = S_ABORT;
            end else begin
               wd_next = wd_step;
            end
         end
         S_COLLECT: begin
            if (pv_reg || A_param_valid) begin
               start_switch_next = 1'b0;
               total_leaked_next = leak_sat;
               if (fail_reg) fail_count_next   = fail_count_reg + 1'b1;
               else          total_errors_next = err_sat;
               frame_done_next = 1'b1;
               frame_fail_next = fail_reg;
               close_fire      = 1'b1;
               ptr_next        = ~ptr_reg;
               a_fin_next      = 1'b0;
               b_fin_next      = 1'b0;
               fail_next       = 1'b0;
               pv_next         = 1'b0;
               frame_next      = frame_reg + 1'b1;
               gap_next        = '0;
               state_next      = S_GAP;
            end else if (wd_expired) begin
               start_switch_next = 1'b0;
               timeout_next      = 1'b1;
               busy_next         = 1'b0;
               state_next        = S_ABORT;
            end else begin
               wd_next = wd_step;
            end
         end
         S_GAP: begin
            if (gap_reg == GAP_LAST) begin
               state_next = (frame_reg == FRAME_LAST) ? S_DONE : S_WAIT_KEY;
            end else begin
               gap_next = gap_reg + 1'b1;
            end
         end
         S_DONE: begin
            run_done_next = 1'b1;
            busy_next     = 1'b0;
            state_next    = S_IDLE;
         end
         S_ABORT: begin
            a_fin_next = 1'b0;
            b_fin_next = 1'b0;
            fail_next  = 1'b0;
            pv_next    = 1'b0;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= S_IDLE;
         frame_reg        <= '0;
         ptr_reg          <= 1'b0;
         wd_reg           <= '0;
         gap_reg          <= '0;
         a_fin_reg        <= 1'b0;
         b_fin_reg        <= 1'b0;
         fail_reg         <= 1'b0;
         pv_reg           <= 1'b0;
         leak_reg         <= '0;
         errcnt_reg       <= '0;
         start_switch_reg <= 1'b0;
         frame_round_reg  <= '0;
         addr_index_reg   <= 1'b0;
         frame_done_reg   <= 1'b0;
         frame_fail_reg   <= 1'b0;
         release_reg      <= '0;
         total_leaked_reg <= '0;
         total_errors_reg <= '0;
         fail_count_reg   <= '0;
         busy_reg         <= 1'b0;
         run_done_reg     <= 1'b0;
         timeout_reg      <= 1'b0;
      end else begin
         state_reg        <= state_next;
         frame_reg        <= frame_next;
         ptr_reg          <= ptr_next;
         wd_reg           <= wd_next;
         gap_reg          <= gap_next;
         a_fin_reg        <= a_fin_next;
         b_fin_reg        <= b_fin_next;
         fail_reg         <= fail_next;
         pv_reg           <= pv_next;
         leak_reg         <= leak_next;
         errcnt_reg       <= errcnt_next;
         start_switch_reg <= start_switch_next;
         frame_round_reg  <= frame_round_next;
         addr_index_reg   <= addr_index_next;
         frame_done_reg   <= frame_done_next;
         frame_fail_reg   <= frame_fail_next;
         release_reg      <= release_next;
         total_leaked_reg <= total_leaked_next;
         total_errors_reg <= total_errors_next;
         fail_count_reg   <= fail_count_next;
         busy_reg         <= busy_next;
         run_done_reg     <= run_done_next;
         timeout_reg      <= timeout_next;
      end
   end

   assign sifted_bank_release = release_reg;
   assign er_start_switch     = start_switch_reg;
   assign er_frame_round      = frame_round_reg;
   assign er_addr_index       = addr_index_reg;
   assign frame_done          = frame_done_reg;
   assign frame_fail          = frame_fail_reg;
   assign total_leaked        = total_leaked_reg;
   assign total_errors        = total_errors_reg;
   assign fail_count          = fail_count_reg;
   assign busy                = busy_reg;
   assign run_done            = run_done_reg;
   assign timeout_err         = timeout_reg;

endmodule

// File: tb/tb_er_frame_scheduler.sv
// Scoreboard bench for er_frame_scheduler: 4-frame runs, fail frames, late params,
// bank stall, watchdog abort, accumulator saturation and mid-run reset.
module tb_er_frame_scheduler;

   localparam int FRW = 6;
   localparam int TOT_W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n = 1'b0;
   logic             run_start = 1'b0;
   logic [1:0]       sifted_bank_ready = 2'b11;
   logic [1:0]       sifted_bank_release;
   logic             er_start_switch;
   logic [FRW-1:0]   er_frame_round;
   logic             er_addr_index;
   logic             A_finish = 1'b0, B_finish = 1'b0, A_fail = 1'b0, B_fail = 1'b0;
   logic             A_param_valid = 1'b0;
   logic [15:0]      A_leaked_info = '0;
   logic [15:0]      A_error_count = '0;
   logic             frame_done, frame_fail;
   logic [TOT_W-1:0] total_leaked, total_errors;
   logic [FRW:0]     fail_count;
   logic             busy, run_done, timeout_err;

   er_frame_scheduler #(
      .FRAME_NUM(4), .FRAME_ROUND_WIDTH(FRW), .LEAK_W(16), .ERRCNT_W(16),
      .TOT_W(TOT_W), .TIMEOUT_CYCLES(200), .GAP_CYCLES(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .run_start(run_start),
      .sifted_bank_ready(sifted_bank_ready), .sifted_bank_release(sifted_bank_release),
      .er_start_switch(er_start_switch), .er_frame_round(er_frame_round),
      .er_addr_index(er_addr_index), .A_finish(A_finish), .B_finish(B_finish),
      .A_fail(A_fail), .B_fail(B_fail), .A_param_valid(A_param_valid),
      .A_leaked_info(A_leaked_info), .A_error_count(A_error_count),
      .frame_done(frame_done), .frame_fail(frame_fail),
      .total_leaked(total_leaked), .total_errors(total_errors), .fail_count(fail_count),
      .busy(busy), .run_done(run_done), .timeout_err(timeout_err)
   );

   typedef struct packed {
      logic [FRW-1:0] round;
      logic           addr;
      logic           fail;
      logic [1:0]     rel;
   } frame_rec_t;

   frame_rec_t exp_q[$];
   frame_rec_t obs_q[$];
   int errors = 0;
   int checks = 0;
   int run_done_cnt = 0;
   int rel_cnt = 0;
   int done_cnt = 0;

   always @(negedge clk) begin
      frame_rec_t r;
      if (rst_n && frame_done) begin
         r.round = er_frame_round;
         r.addr  = er_addr_index;
         r.fail  = frame_fail;
         r.rel   = sifted_bank_release;
         obs_q.push_back(r);
         done_cnt++;
      end
      if (rst_n && run_done) run_done_cnt++;
      if (rst_n && (sifted_bank_release != 2'b00)) rel_cnt++;
   end

   function automatic frame_rec_t mk(input int f, input bit fl);
      frame_rec_t r;
      r.round = f[FRW-1:0];
      r.addr  = f[0];
      r.fail  = fl;
      r.rel   = f[0] ? 2'b10 : 2'b01;
      return r;
   endfunction

   task automatic start_run();
      obs_q.delete();
      exp_q.delete();
      run_done_cnt = 0;
      rel_cnt = 0;
      @(posedge clk); #1 run_start = 1'b1;
      @(posedge clk); #1 run_start = 1'b0;
   endtask

   // ER-pair model: wait for launch, finish fin_dly cycles later, param pv_dly after finish.
   task automatic drive_frame(input int fin_dly, input bit af, input bit bf, input int leak,
                              input int err, input int pv_dly, output bit launched,
                              output bit early, output int close_lat);
      int n;
      int d0;
      launched = 1'b0; early = 1'b0; close_lat = -1; n = 0;
      while (!launched && n < 2000) begin
         @(negedge clk); n++;
         if (er_start_switch) launched = 1'b1;
      end
      if (!launched) return;
      d0 = done_cnt;
      repeat (fin_dly) @(posedge clk);
      #1 A_finish = 1'b1; B_finish = 1'b1; A_fail = af; B_fail = bf;
      A_leaked_info = 16'(leak); A_error_count = 16'(err);
      if (pv_dly == 0) A_param_valid = 1'b1;
      @(posedge clk);
      #1 A_finish = 1'b0; B_finish = 1'b0; A_fail = 1'b0; B_fail = 1'b0; A_param_valid = 1'b0;
      if (pv_dly > 0) begin
         repeat (pv_dly - 1) @(posedge clk);
         #1 early = (done_cnt != d0);
         A_param_valid = 1'b1;
         @(posedge clk);
         #1 A_param_valid = 1'b0;
      end
      n = 0;
      while (close_lat < 0 && n < 50) begin
         @(negedge clk); n++;
         if (frame_done) close_lat = n;
      end
      #2;
   endtask

   task automatic wait_idle(output bit ok);
      int n;
      n = 0; ok = 1'b0;
      while (!ok && n < 500) begin
         @(negedge clk); n++;
         if (!busy) ok = 1'b1;
      end
      #2;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (er_start_switch !== 1'b0) begin errors++; $display("FAIL reset_start_switch: got %b want 0", er_start_switch); end
      checks++; if (busy !== 1'b0 || run_done !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL reset_status: busy=%b run_done=%b timeout=%b want 0", busy, run_done, timeout_err); end
      checks++; if (total_leaked !== '0 || total_errors !== '0 || fail_count !== '0) begin errors++; $display("FAIL reset_totals: leak=%0d err=%0d fails=%0d want 0", total_leaked, total_errors, fail_count); end
      checks++; if (frame_done !== 1'b0 || sifted_bank_release !== 2'b00 || er_frame_round !== '0 || er_addr_index !== 1'b0) begin errors++; $display("FAIL reset_frame_outs: done=%b rel=%b round=%0d addr=%b want 0", frame_done, sifted_bank_release, er_frame_round, er_addr_index); end
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_basic_run();
      bit la, early, ok; int lat; frame_rec_t o, e;
      start_run();
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
      for (int f = 0; f < 4; f++) begin
         exp_q.push_back(mk(f, 1'b0));
         drive_frame(100, 1'b0, 1'b0, 10, 3, 0, la, early, lat);
         checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL basic_frame%0d: got no frame_done want one", f); end
         else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            $display("frame round=%0d addr=%0d fail=%0d rel=%b", o.round, o.addr, o.fail, o.rel);
            if (o !== e) begin errors++; $display("FAIL basic_frame%0d: got round=%0d addr=%b fail=%b rel=%b want round=%0d addr=%b fail=%b rel=%b", f, o.round, o.addr, o.fail, o.rel, e.round, e.addr, e.fail, e.rel); end
         end
         if (f == 1) begin
            @(posedge clk); #1 run_start = 1'b1;
            @(posedge clk); #1 run_start = 1'b0;
         end
      end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_idle: busy never dropped"); end
      repeat (5) @(negedge clk);
      checks++; if (total_leaked !== 8'd40) begin errors++; $display("FAIL basic_leaked: got %0d want 40", total_leaked); end
      checks++; if (total_errors !== 8'd12) begin errors++; $display("FAIL basic_errors: got %0d want 12", total_errors); end
      checks++; if (run_done_cnt !== 1) begin errors++; $display("FAIL basic_run_done: got %0d pulses want 1", run_done_cnt); end
   endtask

   task automatic test_fail_frame();
      bit la, early, ok; int lat; frame_rec_t o, e;
      start_run();
      for (int f = 0; f < 4; f++) begin
         exp_q.push_back(mk(f, f == 1));
         drive_frame(30, 1'b0, f == 1, 10, 3, 0, la, early, lat);
         checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL fail_frame%0d: got no frame_done want one", f); end
         else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            $display("frame round=%0d addr=%0d fail=%0d rel=%b", o.round, o.addr, o.fail, o.rel);
            if (o !== e) begin errors++; $display("FAIL fail_frame%0d: got round=%0d fail=%b rel=%b want round=%0d fail=%b rel=%b", f, o.round, o.fail, o.rel, e.round, e.fail, e.rel); end
         end
         if (f == 0) begin
            // stray pulses during the inter-frame gap must be ignored
            @(posedge clk); #1 A_finish = 1'b1; B_finish = 1'b1; A_param_valid = 1'b1; A_leaked_info = 16'd99;
            @(posedge clk); #1 A_finish = 1'b0; B_finish = 1'b0; A_param_valid = 1'b0;
         end
      end
      wait_idle(ok);
      checks++; if (total_leaked !== 8'd40) begin errors++; $display("FAIL fail_leaked: got %0d want 40", total_leaked); end
      checks++; if (total_errors !== 8'd9) begin errors++; $display("FAIL fail_errors: got %0d want 9", total_errors); end
      checks++; if (fail_count !== 7'd1) begin errors++; $display("FAIL fail_count: got %0d want 1", fail_count); end
   endtask

   task automatic test_late_param();
      bit la, early, ok; int lat;
      start_run();
      drive_frame(20, 1'b0, 1'b0, 10, 3, 5, la, early, lat);
      $display("frame late-param close latency=%0d early=%0d", lat, early);
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL late_param_early: frame closed before param"); end
      checks++; if (lat != 1) begin errors++; $display("FAIL late_param_latency: got %0d want 1", lat); end
      for (int f = 1; f < 4; f++) drive_frame(20, 1'b0, 1'b0, 10, 3, 0, la, early, lat);
      wait_idle(ok);
      checks++; if (total_leaked !== 8'd40 || total_errors !== 8'd12) begin errors++; $display("FAIL late_param_totals: got leak=%0d err=%0d want 40/12", total_leaked, total_errors); end
   endtask

   task automatic test_bank_stall();
      bit la, early, ok; int lat, hi, n;
      sifted_bank_ready = 2'b01;
      start_run();
      drive_frame(20, 1'b0, 1'b0, 10, 3, 0, la, early, lat);
      hi = 0;
      repeat (50) begin @(negedge clk); if (er_start_switch) hi++; end
      checks++; if (hi != 0) begin errors++; $display("FAIL stall_switch_low: got %0d high cycles want 0", hi); end
      @(posedge clk); #1 sifted_bank_ready = 2'b11;
      n = 0;
      while (n < 20) begin @(negedge clk); if (er_start_switch) break; n++; end
      $display("frame 1 launch after bank ready: %0d cycles", n);
      checks++; if (n != 1) begin errors++; $display("FAIL stall_launch_latency: got %0d want 1", n); end
      checks++; if (er_addr_index !== 1'b1 || er_frame_round !== 6'd1) begin errors++; $display("FAIL stall_launch_ids: got addr=%b round=%0d want 1/1", er_addr_index, er_frame_round); end
      for (int f = 1; f < 4; f++) drive_frame(20, 1'b0, 1'b0, 10, 3, 0, la, early, lat);
      wait_idle(ok);
      checks++; if (total_leaked !== 8'd40) begin errors++; $display("FAIL stall_leaked: got %0d want 40", total_leaked); end
   endtask

   task automatic test_timeout();
      int hi, n;
      start_run();
      n = 0;
      while (!er_start_switch && n < 100) begin @(negedge clk); n++; end
      fork
         begin
            repeat (50) @(posedge clk);
            #1 A_finish = 1'b1;
            @(posedge clk); #1 A_finish = 1'b0;
         end
      join_none
      hi = 0;
      while (er_start_switch && hi < 1000) begin hi++; @(negedge clk); end
      $display("timeout: start_switch high for %0d cycles", hi);
      checks++; if (hi != 200) begin errors++; $display("FAIL timeout_cycles: got %0d want 200", hi); end
      checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_flags: got timeout=%b busy=%b want 1/0", timeout_err, busy); end
      repeat (5) @(negedge clk);
      checks++; if (obs_q.size() != 0 || rel_cnt != 0) begin errors++; $display("FAIL timeout_no_close: got %0d frame_done %0d release want 0/0", obs_q.size(), rel_cnt); end
      start_run();
      @(negedge clk);
      checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_clear: got timeout=%b busy=%b want 0/1", timeout_err, busy); end
      #2 rst_n = 1'b0;
      #10 rst_n = 1'b1;
   endtask

   task automatic test_saturate();
      bit la, early, ok; int lat;
      start_run();
      drive_frame(20, 1'b0, 1'b0, 200, 3, 0, la, early, lat);
      checks++; if (total_leaked !== 8'd200) begin errors++; $display("FAIL sat_first: got %0d want 200", total_leaked); end
      drive_frame(20, 1'b0, 1'b0, 200, 3, 0, la, early, lat);
      checks++; if (total_leaked !== 8'd255) begin errors++; $display("FAIL sat_second: got %0d want 255", total_leaked); end
      for (int f = 2; f < 4; f++) drive_frame(20, 1'b0, 1'b0, 200, 3, 0, la, early, lat);
      wait_idle(ok);
      checks++; if (total_leaked !== 8'd255 || total_errors !== 8'd12) begin errors++; $display("FAIL sat_final: got leak=%0d err=%0d want 255/12", total_leaked, total_errors); end
   endtask

   task automatic test_reset_mid_run();
      bit la, early; int lat, n;
      start_run();
      drive_frame(20, 1'b0, 1'b0, 10, 3, 0, la, early, lat);
      n = 0;
      while (!er_start_switch && n < 100) begin @(negedge clk); n++; end
      repeat (5) @(posedge clk);
      checks++; if (er_start_switch !== 1'b1 || total_leaked !== 8'd10) begin errors++; $display("FAIL midrun_pre: got switch=%b leak=%0d want 1/10", er_start_switch, total_leaked); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if (er_start_switch !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrun_async: got switch=%b busy=%b want 0/0", er_start_switch, busy); end
      checks++; if (er_frame_round !== '0 || er_addr_index !== 1'b0 || total_leaked !== '0 || total_errors !== '0) begin errors++; $display("FAIL midrun_values: got round=%0d addr=%b leak=%0d err=%0d want 0", er_frame_round, er_addr_index, total_leaked, total_errors); end
      #20 rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic_run();
      test_fail_frame();
      test_late_param();
      test_bank_stall();
      test_timeout();
      test_saturate();
      test_reset_mid_run();
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
